pow_arbiter: RTL
================

Name: pow_arbiter

Overview:
- Shares one iterative fixed-point power engine (x^POWER, Q-format) among NUM_REQ requesters in the feature-extraction pipeline, e.g. several frame or bin streams.
- Arbitration is round-robin. The block accepts one sample at a time and sequences the multiply iterations.
- Each result is returned with the index of the requester that supplied the sample, over a valid/ready output handshake.

Parameters:
- NUM_REQ, 4, number of requesters; range 2..8.
- Q, 15, fractional bits of the input samples.
- POWER, 2, integer exponent; range 1..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req_valid  input  NUM_REQ  per-requester sample valid.
- req_data  input  16*NUM_REQ  packed signed Q samples; requester i occupies bits [16i+15:16i].
- req_ready  output  NUM_REQ  one-hot accept; combinational.
- out_valid  output  1  result valid; registered.
- out_data  output  32  signed result, Q fractional bits; registered.
- out_id  output  $clog2(NUM_REQ)  requester index of the result; registered.
- out_ready  input  1  downstream accept.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1) clears: state=IDLE, rr_ptr=0, cnt=0, x_reg=0, acc=0, out_valid=0, out_data=0, out_id=0.
- Reset asserted mid-operation abandons any sample in flight; no result is emitted for it.
- States: IDLE, MUL, OUT.
- IDLE, grant:
  - g = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready[g]=1 only when state=IDLE and at least one req_valid is high. In every other case req_ready is all zero.
- IDLE, accept edge (req_valid[g]=1):
  - x_reg<=req_data[g]; acc<=sign-extended req_data[g]; out_id<=g; rr_ptr<=(g+1) mod NUM_REQ; cnt<=0.
  - POWER=1: out_data<=sign-extended sample, out_valid<=1, go to OUT.
  - Otherwise go to MUL.
- MUL, one multiply per cycle:
  - prod = acc*x_reg, 48-bit signed; next = prod >>> Q (arithmetic, floor), truncated to 32 bits.
  - If cnt==POWER-2: out_data<=next, out_valid<=1, go to OUT.
  - Else: acc<=next, cnt<=cnt+1.
- Overflow: inputs lie in [-1,1), so |acc| <= 2^Q and truncation never loses significance.
- OUT:
  - out_valid, out_data and out_id are held stable until out_ready=1.
  - On the edge where out_valid&out_ready: out_valid<=0, go to IDLE. No new accept occurs in that same cycle.
- Latency, for POWER>=2:
  - out_valid rises on the (POWER-1)th edge after the accepting edge.
  - With POWER=1 it rises on the accepting edge.
- Throughput with out_ready held high: one result per POWER+1 cycles.
- rr_ptr advances only on accept. A requester that drops req_valid before being granted loses nothing; no state is kept for it.
- Requesters must hold req_data[i] stable while req_valid[i]=1. Only the granted requester's data is sampled.
- Changes to req_valid outside IDLE have no effect.

Test Plan:
- POWER=2, Q=15, requester 2 sends 0x4000 (0.5):
  - req_ready=4'b0100 in the same cycle.
  - out_valid 1 edge after accept, out_data=0x00002000, out_id=2.
- POWER=2, requester 0 sends 0x8000 (-1.0):
  - out_data=0x00008000 (+1.0).
  - Then sends 0xC000 (-0.5): out_data=0x00002000.
- Fairness: all four req_valid held high, out_ready=1 → grant/out_id order 0,1,2,3,0,1; accepts are spaced exactly 3 cycles apart.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises:
  - out_data and out_id are stable and req_ready stays 0 throughout.
  - Accept happens on the cycle out_ready rises; next req_ready appears the following cycle.
- POWER=3, input 0x4000 → out_data=0x00001000 two edges after accept. POWER=1, input 0xFFFF → out_data=0xFFFFFFFF on the accept edge.
- Reset mid-MUL (POWER=4, input 0x7FFF, assert rst asynchronously between edges):
  - Outputs clear immediately without waiting for a clock edge: out_valid=0, busy=0.
  - After release, requester 0 wins again (rr_ptr=0) and no stale result appears.

Source files
------------

// File: rtl/pow_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pow_arbiter: round-robin shared iterative fixed-point x^POWER engine
// Rev 1.0
// ---------------------------------------------------------------------------
module pow_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int Q       = 15,
   parameter int POWER   = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [16*NUM_REQ-1:0]      req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       out_valid,
   output logic [31:0]                out_data,
   output logic [$clog2(NUM_REQ)-1:0] out_id,
   input  logic                       out_ready,
   output logic                       busy
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [ID_W-1:0]     rr_ptr;
   logic [CNT_W-1:0]    cnt;
   logic signed [15:0]  x_reg;
   logic signed [31:0]  acc;

   logic [ID_W-1:0]     grant_id;
   logic                grant_any;
   logic                accept;
   logic                mul_last;
   logic [15:0]         sample;
   logic [31:0]         sample_ext;
   logic signed [47:0]  prod;
   logic [31:0]         mul_next;

   // Reverse scan so the requester closest to rr_ptr wins.
   always_comb begin
      int idx;
      grant_id  = '0;
      grant_any = 1'b0;
      idx       = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (req_valid[idx[ID_W-1:0]]) begin
            grant_any = 1'b1;
            grant_id  = idx[ID_W-1:0];
         end
      end
   end

   assign accept     = (state == IDLE) && grant_any;
   assign sample     = req_data[16*grant_id +: 16];
   assign sample_ext = {{16{sample[15]}}, sample};
   assign mul_last   = (cnt == CNT_W'(POWER - 2));
   assign busy       = (state != IDLE);

   // Sign-extended 48-bit product; the low 48 bits are exact for two's complement.
   assign prod     = $signed({{16{acc[31]}}, acc}) * $signed({{32{x_reg[15]}}, x_reg});
   assign mul_next = 32'(prod >>> Q);

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[grant_id] = 1'b1;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (grant_any) state_nx = (POWER == 1) ? OUT : MUL;
         MUL:     if (mul_last) state_nx = OUT;
         OUT:     if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr    <= '0;
         cnt       <= '0;
         x_reg     <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= '0;
      end else if (accept) begin
         x_reg  <= sample;
         acc    <= sample_ext;
         out_id <= grant_id;
         rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
         cnt    <= '0;
         if (POWER == 1) begin
            out_data  <= sample_ext;
            out_valid <= 1'b1;
         end
      end else if (state == MUL) begin
         if (mul_last) begin
            out_data  <= mul_next;
            out_valid <= 1'b1;
         end else begin
            acc <= mul_next;
            cnt <= cnt + CNT_W'(1);
         end
      end else if (state == OUT && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
`default_nettype wire
